// File: rtl/hit_detector_pkg.sv
// hit_detector_pkg: shared FSM state encoding and default screen geometry for the hit detector
// Ports: none (package). Provides state_t plus DEF_H_ACTIVE / DEF_V_ACTIVE.
package hit_detector_pkg;
   typedef enum logic [1:0] {
      SYNC = 2'd0,
      SCAN = 2'd1,
      EVAL = 2'd2
   } state_t;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
endpackage

// File: rtl/pixel_advance_detect.sv
// pixel_advance_detect: registers the pixel coordinates and strobes once per newly presented pixel
// Ports: clk_calculation, reset (sync, active-high); x, y, pixel_valid in; new_pixel out (combinational).
module pixel_advance_detect (
   input  logic       clk_calculation,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       pixel_valid,
   output logic       new_pixel
);
   logic [9:0] x_q, x_d, y_q, y_d;
   always_comb begin
      x_d = x;
      y_d = y;
   end
   // 10'h3FF lies outside any active area, so the first pixel after reset always reads as new
   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         x_q <= 10'h3FF;
         y_q <= 10'h3FF;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
   assign new_pixel = pixel_valid && (x != x_q || y != y_q);
endmodule

// File: rtl/player_hit_detector.sv
// player_hit_detector: counts player/attack overlap pixels per frame and reports a hit verdict
// Ports: clk_calculation, reset (sync, active-high); x, y, pixel_valid give the scanned pixel;
//        player_signal, attack_signal, attack_enable classify it; is_trigger_player and
//        hit_pixel_count hold the last evaluated frame; frame_done pulses in the evaluation cycle.
// Option: define PLAYER_IFRAME_EN to mask hits for IFRAME_FRAMES evaluations after each hit.
module player_hit_detector
   import hit_detector_pkg::*;
#(
   parameter int H_ACTIVE      = DEF_H_ACTIVE,
   parameter int V_ACTIVE      = DEF_V_ACTIVE,
   parameter int MIN_OVERLAP   = 4,
   parameter int IFRAME_FRAMES = 30,
   parameter int COUNT_WIDTH   = 12
) (
   input  logic                   clk_calculation,
   input  logic                   reset,
   input  logic [9:0]             x,
   input  logic [9:0]             y,
   input  logic                   pixel_valid,
   input  logic                   player_signal,
   input  logic                   attack_signal,
   input  logic                   attack_enable,
   output logic                   is_trigger_player,
   output logic [COUNT_WIDTH-1:0] hit_pixel_count,
   output logic                   frame_done
);
   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, hit_pixel_count_q, hit_pixel_count_d;
   logic                   is_trigger_player_q, is_trigger_player_d;
   logic                   new_pixel, at_first, at_last, overlap, hit;

   if (MIN_OVERLAP < 1 || MIN_OVERLAP > 4095 || IFRAME_FRAMES < 0) begin : g_bad_cfg
      $error("player_hit_detector: MIN_OVERLAP or IFRAME_FRAMES out of range");
   end

   pixel_advance_detect u_adv (
      .clk_calculation (clk_calculation),
      .reset           (reset),
      .x               (x),
      .y               (y),
      .pixel_valid     (pixel_valid),
      .new_pixel       (new_pixel)
   );

   assign at_first = new_pixel && x == '0 && y == '0;
   assign at_last  = new_pixel && x == 10'(H_ACTIVE - 1) && y == 10'(V_ACTIVE - 1);
   assign overlap  = player_signal && attack_signal && attack_enable;
   assign hit      = cnt_q >= COUNT_WIDTH'(MIN_OVERLAP);

`ifdef PLAYER_IFRAME_EN
   localparam int IW = $clog2(IFRAME_FRAMES + 2);
   logic [IW-1:0] iframe_q, iframe_d;
`endif

   always_ff @(posedge clk_calculation) begin
      if (reset) state_q <= SYNC;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    state_d = at_first ? SCAN : SYNC;
         SCAN:    state_d = at_last ? EVAL : SCAN;
         default: state_d = SYNC;
      endcase
   end

   // A (0,0) pixel seen in SYNC or mid-SCAN starts a fresh count that already includes that pixel
   always_comb begin
      cnt_d               = cnt_q;
      hit_pixel_count_d   = hit_pixel_count_q;
      is_trigger_player_d = is_trigger_player_q;
`ifdef PLAYER_IFRAME_EN
      iframe_d            = iframe_q;
`endif
      if (state_q == EVAL) begin
         cnt_d             = '0;
         hit_pixel_count_d = cnt_q;
`ifdef PLAYER_IFRAME_EN
         is_trigger_player_d = hit && iframe_q == '0;
         iframe_d            = iframe_q != '0 ? iframe_q - 1'b1 : hit ? IW'(IFRAME_FRAMES) : '0;
`else
         is_trigger_player_d = hit;
`endif
      end else if (at_first) cnt_d = overlap ? COUNT_WIDTH'(1) : '0;
      else if (state_q == SCAN && new_pixel && overlap && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_calculation) begin
      if (reset) begin
         cnt_q               <= '0;
         hit_pixel_count_q   <= '0;
         is_trigger_player_q <= 1'b0;
`ifdef PLAYER_IFRAME_EN
         iframe_q            <= '0;
`endif
      end else begin
         cnt_q               <= cnt_d;
         hit_pixel_count_q   <= hit_pixel_count_d;
         is_trigger_player_q <= is_trigger_player_d;
`ifdef PLAYER_IFRAME_EN
         iframe_q            <= iframe_d;
`endif
      end
   end

   assign frame_done        = state_q == EVAL;
   assign hit_pixel_count   = hit_pixel_count_q;
   assign is_trigger_player = is_trigger_player_q;
endmodule

// File: tb/tb_player_hit_detector.sv
// tb_player_hit_detector: directed frames against a frame-level reference model of the hit detector
module tb_player_hit_detector;
   localparam int H = 65, V = 64, NPIX = H * V, MIN_OV = 4, CW = 12, IFR = 3, CMAX = 4095;
   logic          clk_calculation = 1'b0;
   logic          reset = 1'b1;
   logic [9:0]    x = '1, y = '1;
   logic          pixel_valid = 1'b0, player_signal = 1'b0, attack_signal = 1'b0, attack_enable = 1'b0;
   logic          is_trigger_player, frame_done;
   logic [CW-1:0] hit_pixel_count;
   int checks = 0, errors = 0, cyc = 0, done_pulses = 0;
   int cur_cnt = 0, cur_trig = 0, nxt_cnt = 0, nxt_trig = 0, eval_cyc = -1, iframe_m = 0;
   bit chk_en = 1'b0;

   player_hit_detector #(
      .H_ACTIVE(H), .V_ACTIVE(V), .MIN_OVERLAP(MIN_OV), .IFRAME_FRAMES(IFR), .COUNT_WIDTH(CW)
   ) dut (
      .clk_calculation   (clk_calculation),
      .reset             (reset),
      .x                 (x),
      .y                 (y),
      .pixel_valid       (pixel_valid),
      .player_signal     (player_signal),
      .attack_signal     (attack_signal),
      .attack_enable     (attack_enable),
      .is_trigger_player (is_trigger_player),
      .hit_pixel_count   (hit_pixel_count),
      .frame_done        (frame_done)
   );

   always #5 clk_calculation = ~clk_calculation;
   always @(posedge clk_calculation) cyc <= cyc + 1;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Verdict of an evaluation in cycle E becomes visible from cycle E+1 onward
   always @(negedge clk_calculation) if (chk_en) begin
      check("frame_done", int'(frame_done), int'(cyc == eval_cyc));
      check("hit_pixel_count", int'(hit_pixel_count), (eval_cyc >= 0 && cyc > eval_cyc) ? nxt_cnt : cur_cnt);
      check("is_trigger_player", int'(is_trigger_player), (eval_cyc >= 0 && cyc > eval_cyc) ? nxt_trig : cur_trig);
      if (frame_done) done_pulses++;
   end

   task automatic tick();
      @(posedge clk_calculation);
      #1;
   endtask

   // Called while the frame's last pixel is being presented: evaluation follows next cycle
   task automatic expect_eval(int first, int n, bit en);
      int ov = en ? ((first + n > NPIX ? NPIX : first + n) - first) : 0;
      if (eval_cyc >= 0) begin
         cur_cnt  = nxt_cnt;
         cur_trig = nxt_trig;
      end
      nxt_cnt = ov > CMAX ? CMAX : ov;
`ifdef PLAYER_IFRAME_EN
      if (iframe_m > 0) begin
         iframe_m--;
         nxt_trig = 0;
      end else begin
         nxt_trig = int'(nxt_cnt >= MIN_OV);
         if (nxt_trig == 1) iframe_m = IFR;
      end
`else
      nxt_trig = int'(nxt_cnt >= MIN_OV);
`endif
      eval_cyc = cyc + 1;
   endtask

   task automatic put(int p, bit ov, bit en, int hold);
      x             = 10'(p % H);
      y             = 10'(p / H);
      pixel_valid   = 1'b1;
      player_signal = ov | (p % 3 == 1);
      attack_signal = ov | (p % 3 == 2);
      attack_enable = en;
      repeat (hold) tick();
   endtask

   task automatic blank(int n);
      pixel_valid   = 1'b0;
      player_signal = 1'b0;
      attack_signal = 1'b0;
      repeat (n) tick();
   endtask

   // Overlap on pixels [first, first+n); stop >= 0 truncates the frame before pixel index stop
   task automatic frame(int first, int n, bit en, int hold, int stop);
      int last = stop < 0 ? NPIX : stop;
      for (int p = 0; p < last; p++) begin
         if (p == NPIX - 1) expect_eval(first, n, en);
         put(p, p >= first && p < first + n, en, hold);
      end
      if (stop < 0) blank(4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      cur_cnt  = 0;
      cur_trig = 0;
      eval_cyc = -1;
      iframe_m = 0;
      tick();
      reset       = 1'b0;
      pixel_valid = 1'b0;
   endtask

   initial begin
      int d0;
      int seq[5], exp_seq[5];
`ifdef PLAYER_IFRAME_EN
      exp_seq = '{1, 0, 0, 0, 1};
`else
      exp_seq = '{1, 1, 1, 1, 1};
`endif
      tick();
      tick();
      chk_en = 1'b1;
      reset  = 1'b0;
      check("reset count", int'(hit_pixel_count), 0);
      check("reset trigger", int'(is_trigger_player), 0);
      check("reset frame_done", int'(frame_done), 0);
      blank(3);

      d0 = done_pulses;
      frame(100, 10, 1'b1, 4, -1);
      check("held pixels count", int'(hit_pixel_count), 10);
      check("held pixels trigger", int'(is_trigger_player), 1);
      check("held pixels pulses", done_pulses - d0, 1);

      frame(500, 3, 1'b1, 1, -1);
      check("below threshold count", int'(hit_pixel_count), 3);
      check("below threshold trigger", int'(is_trigger_player), 0);

      frame(500, 25, 1'b0, 1, -1);
      check("disabled count", int'(hit_pixel_count), 0);
      check("disabled trigger", int'(is_trigger_player), 0);

      frame(NPIX - 1, 1, 1'b1, 1, -1);
      check("last pixel count", int'(hit_pixel_count), 1);

      frame(0, 50, 1'b1, 1, 32 * H + 32);
      put(32 * H + 32, 1'b1, 1'b1, 0);
      do_reset();
      check("mid-frame reset count", int'(hit_pixel_count), 0);
      check("mid-frame reset trigger", int'(is_trigger_player), 0);
      blank(2);
      frame(200, 5, 1'b1, 1, -1);
      check("after reset count", int'(hit_pixel_count), 5);

      d0 = done_pulses;
      frame(0, 20, 1'b1, 1, 1000);
      check("truncated no pulse", done_pulses - d0, 0);
      frame(300, 7, 1'b1, 1, -1);
      check("restarted count", int'(hit_pixel_count), 7);
      check("restarted pulses", done_pulses - d0, 1);

      do_reset();
      blank(2);
      for (int f = 0; f < 5; f++) begin
         frame(40 * f, 8, 1'b1, 1, -1);
         seq[f] = int'(is_trigger_player);
      end
      for (int f = 0; f < 5; f++) check($sformatf("trigger seq[%0d]", f), seq[f], exp_seq[f]);

      frame(0, NPIX, 1'b1, 1, -1);
      check("saturated count", int'(hit_pixel_count), 4095);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
